// File: rtl/pipeline_int_seq.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_int_seq
// Purpose  : Interrupt entry sequencer for the 3-stage RAT pipeline.
//            - Synchronizes irq and latches a pending request.
//            - Waits for a safe point: I flag set, no branch in EX, no ROM replay.
//            - Drains the pipe by holding fetch and forcing decode NOPs.
//            - Injects a one-cycle INT into the decoder.
//            - Steers the prog ROM to the interrupt vector.
//            Its hold/nop outputs are OR-ed with the hazard controller's.
// Ports    : clk          in   system clock (posedge)
//            rst          in   synchronous active-low reset
//            irq          in   external interrupt (asynchronous)
//            i_flag       in   interrupt enable flag
//            ex_is_branch in   EX holds branch/call/ret
//            mem_stall    in   ROM address replayed from delay register
//            fetch_addr   in   address of instruction in fetch register
//            reti_done    in   RETIE executed in EX (1-cycle pulse)
//            fetch_hold   out  freeze fetch register and PC
//            dec_nop      out  force decoder NOP
//            int_inject   out  decoder INT input
//            vec_sel      out  force ROM address to VECTOR_ADDR
//            ret_addr     out  return address to push
//            int_active   out  handler in progress
//            int_pending  out  latched, unserviced request
// Options  : INT_EDGE_DETECT_EN - pending sets on rising edge of the
//            synchronized irq only (default: level sensitive)
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_int_seq #(
    parameter int          SYNC_STAGES  = 2,
    parameter int          DRAIN_CYCLES = 2,
    parameter int unsigned VECTOR_ADDR  = 10'h3FF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       irq,
    input  logic       i_flag,
    input  logic       ex_is_branch,
    input  logic       mem_stall,
    input  logic [9:0] fetch_addr,
    input  logic       reti_done,
    output logic       fetch_hold,
    output logic       dec_nop,
    output logic       int_inject,
    output logic       vec_sel,
    output logic [9:0] ret_addr,
    output logic       int_active,
    output logic       int_pending
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    // The ROM mux owns the vector value; only its range is checked here.
    generate
        if ((SYNC_STAGES < 2) || (DRAIN_CYCLES < 1) || (VECTOR_ADDR > 32'h3FF)) begin : g_bad_params
            $error("pipeline_int_seq: unsupported parameter values");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_INJECT = 3'd2,
        ST_VECTOR = 3'd3,
        ST_ACTIVE = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [9:0]               ret_addr_q, ret_addr_d;
    logic                     pending_q, pending_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     irq_s;
    logic                     irq_evt;
    logic                     fetch_hold_q, dec_nop_q, int_inject_q, vec_sel_q, int_active_q;

    assign irq_s = sync_q[SYNC_STAGES-1];

`ifdef INT_EDGE_DETECT_EN
    // One extra flop so a held level produces a single request.
    logic irq_prev_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_prev_q <= 1'b0;
        end else begin
            irq_prev_q <= irq_s;
        end
    end
    assign irq_evt = irq_s & ~irq_prev_q;
`else
    assign irq_evt = irq_s;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ret_addr_d = ret_addr_q;
        // A new request in the same cycle as the INJECT entry is kept.
        pending_d  = pending_q | irq_evt;
        case (state_q)
            ST_IDLE: begin
                if (pending_q && i_flag && !ex_is_branch && !mem_stall) begin
                    state_d    = ST_DRAIN;
                    cnt_d      = CNT_W'(DRAIN_CYCLES - 1);
                    // The fetched instruction is abandoned and replayed after RETIE.
                    ret_addr_d = fetch_addr;
                end
            end
            ST_DRAIN: begin
                // Committed: a falling I flag no longer aborts the sequence.
                if (cnt_q == '0) begin
                    state_d   = ST_INJECT;
                    pending_d = irq_evt;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_INJECT: state_d = ST_VECTOR;
            ST_VECTOR: state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (reti_done) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ret_addr_q   <= '0;
            pending_q    <= 1'b0;
            sync_q       <= '0;
            fetch_hold_q <= 1'b0;
            dec_nop_q    <= 1'b0;
            int_inject_q <= 1'b0;
            vec_sel_q    <= 1'b0;
            int_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ret_addr_q   <= ret_addr_d;
            pending_q    <= pending_d;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], irq};
            fetch_hold_q <= (state_d == ST_DRAIN);
            dec_nop_q    <= (state_d == ST_DRAIN) || (state_d == ST_VECTOR);
            int_inject_q <= (state_d == ST_INJECT);
            vec_sel_q    <= (state_d == ST_INJECT) || (state_d == ST_VECTOR);
            int_active_q <= (state_d == ST_ACTIVE);
        end
    end

    assign fetch_hold  = fetch_hold_q;
    assign dec_nop     = dec_nop_q;
    assign int_inject  = int_inject_q;
    assign vec_sel     = vec_sel_q;
    assign int_active  = int_active_q;
    assign int_pending = pending_q;
    assign ret_addr    = ret_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_int_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_int_seq
// Purpose  : Directed self-checking bench for pipeline_int_seq (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_int_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       irq;
    logic       i_flag;
    logic       ex_is_branch;
    logic       mem_stall;
    logic [9:0] fetch_addr;
    logic       reti_done;
    logic       fetch_hold;
    logic       dec_nop;
    logic       int_inject;
    logic       vec_sel;
    logic [9:0] ret_addr;
    logic       int_active;
    logic       int_pending;

    int total   = 0;
    int bad     = 0;
    int inj_cnt = 0;

    pipeline_int_seq u_dut (
        .clk          (clk),
        .rst          (rst),
        .irq          (irq),
        .i_flag       (i_flag),
        .ex_is_branch (ex_is_branch),
        .mem_stall    (mem_stall),
        .fetch_addr   (fetch_addr),
        .reti_done    (reti_done),
        .fetch_hold   (fetch_hold),
        .dec_nop      (dec_nop),
        .int_inject   (int_inject),
        .vec_sel      (vec_sel),
        .ret_addr     (ret_addr),
        .int_active   (int_active),
        .int_pending  (int_pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (int_inject === 1'b1) inj_cnt <= inj_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_active(input string tag);
        int n = 0;
        while (int_active !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, int_active, 1);
    endtask

    task automatic finish_service(input string tag);
        wait_active({tag, "_act"});
        reti_done = 1'b1;
        tick();
        reti_done = 1'b0;
        check({tag, "_ret"}, int_active, 0);
    endtask

    logic [9:0] inj_m, hold_m, vec_m, dec_m, pend_m, act_m;
    logic       any_v, all_v;
    int         snap, n;
    logic       sent;

    initial begin
        rst = 1'b0; irq = 1'b0; i_flag = 1'b0; ex_is_branch = 1'b0;
        mem_stall = 1'b0; fetch_addr = '0; reti_done = 1'b0;
        repeat (3) tick();
        check("reset_outs", {fetch_hold, dec_nop, int_inject, vec_sel,
                             int_active, int_pending, ret_addr}, 0);
        rst = 1'b1;
        tick();

        // Basic entry: one-cycle irq, idle pipeline.
        fetch_addr = 10'h012; i_flag = 1'b1; irq = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            irq       = 1'b0;
            inj_m[k]  = int_inject;
            hold_m[k] = fetch_hold;
            vec_m[k]  = vec_sel;
            dec_m[k]  = dec_nop;
            pend_m[k] = int_pending;
            act_m[k]  = int_active;
        end
        check("t1_inject", inj_m,  10'h020);
        check("t1_hold",   hold_m, 10'h018);
        check("t1_vec",    vec_m,  10'h060);
        check("t1_decnop", dec_m,  10'h058);
        check("t1_pend",   pend_m, 10'h01C);
        check("t1_active", act_m,  10'h380);
        check("t1_ret",    ret_addr, 10'h012);
        fetch_addr = 10'h055;
        tick();
        check("t1_ret_stable", ret_addr, 10'h012);
        finish_service("t1");

        // Masked request: pending held, nothing happens until I rises.
        i_flag = 1'b0; irq = 1'b1; any_v = 1'b0; all_v = 1'b1;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (k == 19) irq = 1'b0;
            any_v = any_v | fetch_hold | int_inject | dec_nop | vec_sel;
            if (k >= 3) all_v = all_v & int_pending;
        end
        check("t2_masked_quiet", any_v, 0);
        check("t2_pending_held", all_v, 1);
        i_flag = 1'b1;
        tick();
        check("t2_drain_next", fetch_hold, 1);
        finish_service("t2");

        // Branch in EX then a ROM replay delay entry; ret_addr taken at entry.
        i_flag = 1'b0; irq = 1'b1;
        tick();
        irq = 1'b0;
        repeat (4) tick();
        check("t3_pending", int_pending, 1);
        i_flag = 1'b1; ex_is_branch = 1'b1; any_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fetch_addr = 10'h100 + 10'(k);
            tick();
            any_v = any_v | fetch_hold;
        end
        check("t3_branch_block", any_v, 0);
        ex_is_branch = 1'b0; mem_stall = 1'b1; fetch_addr = 10'h2A5;
        tick();
        check("t3_stall_block", fetch_hold, 0);
        mem_stall = 1'b0;
        tick();
        check("t3_drain", fetch_hold, 1);
        check("t3_ret", ret_addr, 10'h2A5);
        fetch_addr = 10'h111;
        finish_service("t3");
        check("t3_ret_hold", ret_addr, 10'h2A5);

        // Reset during DRAIN aborts with no injection.
        snap = inj_cnt; irq = 1'b1;
        tick();
        irq = 1'b0; n = 0;
        while (fetch_hold !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t4_in_drain", fetch_hold, 1);
        rst = 1'b0;
        tick();
        check("t4_rst_outs", {fetch_hold, dec_nop, int_inject, vec_sel,
                              int_active, int_pending, ret_addr}, 0);
        rst = 1'b1;
        repeat (10) tick();
        check("t4_no_inject", inj_cnt, snap);
        check("t4_no_pending", int_pending, 0);

        // irq during ACTIVE coincident with RETIE: no nesting, then re-entry.
        fetch_addr = 10'h0AA; irq = 1'b1;
        tick();
        irq = 1'b0;
        wait_active("t5_first_act");
        irq = 1'b1;
        tick();
        irq = 1'b0;
        tick();
        check("t5_no_nest", {int_inject, int_active}, 2'b01);
        fetch_addr = 10'h1C3; reti_done = 1'b1;
        tick();
        reti_done = 1'b0;
        check("t5_idle", int_active, 0);
        check("t5_pending", int_pending, 1);
        check("t5_not_early", fetch_hold, 0);
        tick();
        check("t5_reentry", fetch_hold, 1);
        check("t5_ret2", ret_addr, 10'h1C3);
        finish_service("t5");

        // Level held for 50 cycles with a single RETIE.
        snap = inj_cnt; sent = 1'b0; irq = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            reti_done = 1'b0;
            if (int_active === 1'b1 && !sent) begin
                reti_done = 1'b1;
                sent      = 1'b1;
            end
        end
        reti_done = 1'b0; irq = 1'b0;
        repeat (10) tick();
`ifdef INT_EDGE_DETECT_EN
        check("t6_injections", inj_cnt - snap, 1);
`else
        check("t6_injections", inj_cnt - snap, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_int_seq.md
Name: pipeline_int_seq

Overview:
Interrupt entry sequencer for the 3-stage RAT pipeline (fetch / decode+execute / writeback). It synchronizes the external interrupt and gates it with the I flag. It then drains in-flight work by holding fetch and forcing decode NOPs, captures the return address, and injects a one-cycle INT into the decoder. It also steers the prog ROM to the interrupt vector. It sits beside the pipeline hazard controller, and its hold/nop outputs are OR-ed with that controller's.

Parameters:
SYNC_STAGES, 2, flops in irq synchronizer chain (min 2)
DRAIN_CYCLES, 2, NOP cycles inserted before injection (min 1)
VECTOR_ADDR, 10'h3FF, interrupt vector ROM address

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-low reset
irq  in  1  external interrupt, asynchronous to clk
i_flag  in  1  current I (interrupt enable) flag
ex_is_branch  in  1  EX stage holds a branch/call/ret (branch_type != 0)
mem_stall  in  1  ROM address currently replayed from delay register
fetch_addr  in  10  address of instruction in fetch register
reti_done  in  1  1-cycle pulse: RETIE executed in EX
fetch_hold  out  1  freeze fetch register and PC
dec_nop  out  1  force decoder control vector to NOP
int_inject  out  1  drive decoder INT input
vec_sel  out  1  force ROM address to VECTOR_ADDR
ret_addr  out  10  return address to push on stack
int_active  out  1  handler in progress
int_pending  out  1  latched, not yet serviced request

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, synchronizer chain=0, pending=0, ret_addr=0, all 1-bit outputs 0. Reset mid-sequence aborts immediately with no partial injection.
- irq passes through SYNC_STAGES flops, giving irq_s. Level mode: pending set on any cycle with irq_s=1.
- pending clears only on the cycle entering INJECT. int_pending = pending.
- FSM states: IDLE, DRAIN, INJECT, VECTOR, ACTIVE.
- IDLE -> DRAIN when pending & i_flag & !ex_is_branch & !mem_stall.
  - On that transition, ret_addr <= fetch_addr and cnt <= DRAIN_CYCLES-1.
  - The instruction in the fetch register is not executed; it resumes after RETIE.
- DRAIN: fetch_hold=1, dec_nop=1.
  - cnt==0 -> INJECT, else cnt--.
  - i_flag falling during DRAIN does not abort; the sequence is committed.
- INJECT (exactly 1 cycle): int_inject=1, vec_sel=1, fetch_hold=0, dec_nop=0. ret_addr stable.
- VECTOR (1 cycle): vec_sel=1 so the ROM output at VECTOR_ADDR is latched into fetch. dec_nop=1. -> ACTIVE.
- ACTIVE: int_active=1, all other control outputs 0.
  - reti_done -> IDLE.
  - New irq while ACTIVE only sets pending; no nesting.
  - reti_done and irq_s in the same cycle: return to IDLE with pending=1. Re-entry no earlier than the next cycle, still subject to i_flag.
- reti_done outside ACTIVE is ignored.
- Latency: irq rising to int_inject = SYNC_STAGES + 1 + DRAIN_CYCLES + 1 cycles minimum (6 with defaults), extended by ex_is_branch/mem_stall cycles.
- ret_addr holds its value from DRAIN entry until the next DRAIN entry.

Optional Feature:
Macro INT_EDGE_DETECT_EN.
- Defined: pending sets only on a rising edge of irq_s (one extra flop). A level held high causes exactly one service.
- Undefined: level-sensitive, as above. irq still high after RETIE causes immediate re-entry.

Test Plan:
- irq=1 for 1 cycle, i_flag=1, idle pipeline, fetch_addr=10'h012 -> int_inject pulses at cycle 6. ret_addr=10'h012. fetch_hold=1 for exactly 2 cycles before injection. vec_sel=1 for 2 cycles.
- irq=1 with i_flag=0 for 20 cycles, then i_flag=1 -> int_pending=1 throughout, no hold/inject while masked. DRAIN starts on the cycle after i_flag rises.
- Pending set while ex_is_branch=1 for 3 cycles -> DRAIN entry delayed exactly 3 cycles. ret_addr = fetch_addr sampled at entry.
- rst=0 asserted during DRAIN -> next cycle all outputs 0, int_pending=0, and no int_inject ever issued.
- In ACTIVE, irq pulse then reti_done=1 -> IDLE, then re-entry; second ret_addr = new fetch_addr.
- irq held high 50 cycles with one RETIE: with INT_EDGE_DETECT_EN exactly 1 injection, without it 2 injections.
